// File: rtl/keypad_pkg.sv
// Shared keypad-path definitions: loader state encodings and word geometry,
// common to the scanner, the operand loader and the MAC top level.
package keypad_pkg;

  localparam int KEY_DIGITS = 4;
  localparam int NIB_W      = 4;
  localparam int WORD_W     = KEY_DIGITS * NIB_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    OFFER  = 2'b10
  } loader_state_e;

endpackage

// File: rtl/keypad_operand_loader.sv
// Collects four keypad digits per operand, captures operands A and B from the
// scanner's assembled word, and offers the pair to the MAC via valid/ready.
module keypad_operand_loader
  import keypad_pkg::*;
#(
  parameter int PAIR_CNT_W = 8
) (
  input  logic                  Clock,
  input  logic                  reset_n,
  input  logic                  key_ready,
  input  logic [WORD_W-1:0]     key_word,
  output logic                  KeyRd,
  output logic [WORD_W-1:0]     op_a,
  output logic [WORD_W-1:0]     op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [1:0]            nib_idx,
  output logic [PAIR_CNT_W-1:0] pair_count,
  output logic                  key_drop
);

  localparam logic [1:0] LAST_DIGIT = 2'(KEY_DIGITS - 1);

  loader_state_e         state_q, state_d;
  logic [1:0]            nib_q, nib_d;
  logic [WORD_W-1:0]     op_a_q, op_a_d;
  logic [WORD_W-1:0]     op_b_q, op_b_d;
  logic [PAIR_CNT_W-1:0] pair_q, pair_d;
  logic                  drop_q, drop_d;

  // Next-state and datapath update selection.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    pair_d  = pair_q;
    drop_d  = drop_q;
    case (state_q)
      LOAD_A, LOAD_B: begin
        if (key_ready) begin
          if (nib_q == LAST_DIGIT) begin
            nib_d = 2'd0;
            if (state_q == LOAD_A) begin
              op_a_d  = key_word;
              state_d = LOAD_B;
            end else begin
              op_b_d  = key_word;
              state_d = OFFER;
            end
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end else begin
          nib_d = nib_q;
        end
      end
      OFFER: begin
        // op_ready may already be high on entry; the handshake then completes here.
        if (op_ready) begin
          state_d = LOAD_A;
          pair_d  = pair_q + PAIR_CNT_W'(1);
        end else begin
          state_d = OFFER;
        end
        if (key_ready) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = LOAD_A;
      end
    endcase
  end

  // State, digit index, operands, pair counter and sticky drop flag.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      nib_q   <= 2'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      pair_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      pair_q  <= pair_d;
      drop_q  <= drop_d;
    end
  end

  assign KeyRd      = (state_q != OFFER);
  assign op_valid   = (state_q == OFFER);
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign nib_idx    = nib_q;
  assign pair_count = pair_q;
  assign key_drop   = drop_q;

endmodule

// File: doc/keypad_operand_loader.md
# keypad_operand_loader

Consumer side of the keypad path: accepts keys from the keypad scanner through its `KeyRd`/`ready` handshake, counts hex digits, and captures the scanner's assembled 16-bit word as operand A and then operand B. It offers the operand pair to the FP MAC datapath with a valid/ready handshake. It throttles the scanner by withholding `KeyRd` while a pair is pending.

## Interface
Parameters:
- `PAIR_CNT_W`, default 8: width of the completed-pair counter.

Ports:
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. It must be the same reset net that drives the scanner.
- `key_ready`  in  1: one-cycle pulse from the scanner, one pulse per accepted key.
- `key_word`  in  16: scanner's assembled word. Key k (0..3) lands in `[15-4k -: 4]`. The word is valid in the `key_ready` cycle.
- `KeyRd`  out  1: permission for the scanner to release its held key.
- `op_a`  out  16: captured operand A.
- `op_b`  out  16: captured operand B.
- `op_valid`  out  1: the operand pair is offered.
- `op_ready`  in  1: the MAC accepts the pair.
- `nib_idx`  out  2: index of the next expected digit, for display and debug.
- `pair_count`  out  `PAIR_CNT_W`: number of completed handshakes. Wraps modulo 2^`PAIR_CNT_W`.
- `key_drop`  out  1: sticky flag; a key arrived while not loading.

## Operation
- States: LOAD_A = 2'b00, LOAD_B = 2'b01, OFFER = 2'b10. The unused encoding 2'b11 returns to LOAD_A on the next clock.
- Reset values:
  - state = LOAD_A, `nib_idx` = 0
  - `op_a` = `op_b` = 16'h0000
  - `pair_count` = 0, `key_drop` = 0
  - therefore `KeyRd` = 1 and `op_valid` = 0
- `KeyRd` is combinational from state: 1 in LOAD_A/LOAD_B, 0 in OFFER. `op_valid` = (state == OFFER).
- LOAD_A/LOAD_B, on `key_ready`:
  - `nib_idx` 0, 1 or 2: increment `nib_idx`.
  - `nib_idx` == 3: capture `key_word` into `op_a` (LOAD_A) or `op_b` (LOAD_B), set `nib_idx` to 0, and advance to LOAD_B or OFFER respectively.
- OFFER:
  - `op_a`/`op_b` are held stable.
  - On `op_valid && op_ready`: go to LOAD_A and increment `pair_count`.
  - `op_ready` may be high before `op_valid`; the handshake then completes in the first OFFER cycle.
- `key_ready` in OFFER: the key is dropped and `key_drop` is set. `nib_idx` and the operands are unchanged. `key_drop` is cleared only by reset.
- Digit alignment relies on the scanner's internal digit counter being reset by the same `reset_n`. There is no resynchronisation mechanism.
- Reset asserted mid-operand: all state returns to reset values asynchronously, and partially collected digits are discarded.

## Timing
- 4th B-digit `key_ready` at cycle N:
  - `op_b` updated at N+1.
  - `op_valid` high from N+1.
  - `KeyRd` low from N+1.
- Handshake at cycle M: `op_valid` low and `KeyRd` high from M+1; `pair_count` updated at M+1.
- Minimum spacing between scanner keys is at least 10 cycles. A `KeyRd` deassertion at N+1 is therefore always seen before the scanner's next WaitForRead.
- `key_ready` coincident with a handshake in OFFER: the handshake completes, the key is dropped, and `key_drop` is set.
- No combinational path from `key_ready` or `key_word` to any output. `op_ready` affects outputs only through registers.

## Structure
- Shared package `keypad_pkg`:
  - state encodings LOAD_A/LOAD_B/OFFER
  - `KEY_DIGITS` = 4, `NIB_W` = 4, `WORD_W` = 16
  - shared with the scanner and the MAC top level
- No sub-module. One sequential process holds state, `nib_idx`, operands, counter and the sticky flag; `KeyRd`/`op_valid` are continuous assigns.

## Test plan
- Reset check: hold `reset_n` = 0, then release. Expect `KeyRd` = 1, `op_valid` = 0, `op_a` = `op_b` = 0, `nib_idx` = 0, `pair_count` = 0.
- Load one pair: send 4 pulses with final `key_word` = 16'h3C00, then 4 pulses with 16'h4000, `op_ready` = 0. Expect `op_a` = 3C00, `op_b` = 4000, `op_valid` = 1 and `KeyRd` = 0 one cycle after the 8th pulse.
- Handshake: raise `op_ready` for one cycle in OFFER. Expect `pair_count` = 1, then `KeyRd` = 1 and `op_valid` = 0 on the next cycle.
- Drop while pending: `key_ready` pulse in OFFER, including the handshake cycle. Expect `key_drop` = 1 (sticky), `nib_idx` = 0, operands unchanged.
- Abort: assert `reset_n` = 0 after 2 digits of B. Expect an immediate return to reset values; the next 8 keys load a fresh pair.
- Counter wrap: with `PAIR_CNT_W` = 2, run 5 pairs. Expect `pair_count` sequence 1, 2, 3, 0, 1.
